muldiv_scoreboard: RTL and testbench

Sequencing and scheduling controller for a multi-cycle MUL/DIV unit attached to the 5-stage RISC-V pipeline. It accepts an operation from the Execute stage and counts its latency. It tracks the single outstanding destination register and raises stall/bubble requests for dependent or structurally conflicting Decode-stage instructions. It also arbitrates the shared register-file write port against the main pipeline's Writeback stage.

---
 rtl/muldiv_scoreboard.sv | 105 ++++++++++
 tb/tb_muldiv_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_scoreboard.sv
// Sequencing/scoreboard controller for a multi-cycle MUL/DIV unit: latency count,
// outstanding-destination hazard detection and register-file write-port arbitration.
module muldiv_scoreboard #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StartE,
  input  logic       OpE,
  input  logic [4:0] RdE,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic       MulDivD,
  input  logic       RegWriteW,
  output logic       Busy,
  output logic [4:0] BusyRd,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       WbEn,
  output logic [4:0] WbRd
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_WB_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       busy_rd_q, busy_rd_d;
  logic [CNT_W-1:0] lat_m1;
  logic [4:0]       pend_rd;
  logic             active;
  logic             hazard;

  assign lat_m1 = OpE ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_rd_q <= busy_rd_d;
    end
  end

  // Next-state: a WB_WAIT exit may immediately accept a back-to-back op
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_rd_d = busy_rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (StartE) begin
          state_d   = S_BUSY;
          cnt_d     = lat_m1;
          busy_rd_d = RdE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_WB_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB_WAIT: begin
        if (!RegWriteW || (busy_rd_q == 5'd0)) begin
          if (StartE) begin
            state_d   = S_BUSY;
            cnt_d     = lat_m1;
            busy_rd_d = RdE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: forced low while reset is asserted
  always_comb begin
    Busy    = (state_q != S_IDLE);
    BusyRd  = busy_rd_q;
    WbEn    = !rst && (state_q == S_WB_WAIT) && !RegWriteW && (busy_rd_q != 5'd0);
    WbRd    = (state_q == S_WB_WAIT) ? busy_rd_q : 5'd0;
    pend_rd = StartE ? RdE : busy_rd_q;
    active  = StartE || (state_q != S_IDLE);
    hazard  = !rst && active &&
              (((pend_rd != 5'd0) && ((Rs1D == pend_rd) || (Rs2D == pend_rd))) || MulDivD);
    StallF  = hazard;
    StallD  = hazard;
    FlushE  = hazard;
  end

endmodule

// File: tb/tb_muldiv_scoreboard.sv
// Self-checking bench for muldiv_scoreboard: constant vector table, directed
// multi-cycle sequences and a randomized pipeline checked against a cycle-count model.
module tb_muldiv_scoreboard;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 16;
  localparam int unsigned N_RAND  = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       StartE, OpE, MulDivD, RegWriteW;
  logic [4:0] RdE, Rs1D, Rs2D;
  logic       Busy, StallF, StallD, FlushE, WbEn;
  logic [4:0] BusyRd, WbRd;

  int checks = 0;
  int errors = 0;

  muldiv_scoreboard #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .OpE(OpE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .MulDivD(MulDivD), .RegWriteW(RegWriteW),
    .Busy(Busy), .BusyRd(BusyRd), .StallF(StallF), .StallD(StallD),
    .FlushE(FlushE), .WbEn(WbEn), .WbRd(WbRd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, st, op;
    logic [4:0] rd, rs1;
    logic       rw;
    logic       e_busy;
    logic [4:0] e_brd;
    logic       e_stall, e_wb;
    logic [4:0] e_wbrd;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic r, logic st, logic op, logic [4:0] rd, logic [4:0] rs1,
                              logic rw, logic eb, logic [4:0] ebrd, logic es, logic ew,
                              logic [4:0] ewrd);
    vec_t v;
    v.r = r; v.st = st; v.op = op; v.rd = rd; v.rs1 = rs1; v.rw = rw;
    v.e_busy = eb; v.e_brd = ebrd; v.e_stall = es; v.e_wb = ew; v.e_wbrd = ewrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic md,
                       input logic rw);
    rst = r; StartE = st; OpE = op; RdE = rd;
    Rs1D = rs1; Rs2D = rs2; MulDivD = md; RegWriteW = rw;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_stallF"}, 32'(StallF), 32'(exp));
    chk({name, "_stallD"}, 32'(StallD), 32'(exp));
    chk({name, "_flushE"}, 32'(FlushE), 32'(exp));
  endtask

  task automatic end_cycle;
    @(posedge clk);
    #1;
  endtask

  // Random-phase pipeline (D and E registers) and reference model state
  logic       d_v, d_md, d_op, e_v, e_md, e_op;
  logic [4:0] d_rs1, d_rs2, d_rd, e_rd;
  logic       m_have;
  logic [4:0] m_rd;
  int         m_done, cyc;
  logic       r, wp, leave, x_wb, x_h;
  logic [4:0] p;

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);

    // Vector table: MUL rd5 nominal, then MUL rd3 with write-port contention and dependent D
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 5);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 3, 3, 0, 0, 5, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 3, 0, 1, 3, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 3, 0, 1, 3, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 3, 0, 1, 3, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 3, 1, 1, 3, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 3, 1, 1, 3, 1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 3, 1, 1, 3, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 3, 0, 1, 3, 1, 1, 3);
    tbl[16] = mk(0, 0, 0, 0, 3, 0, 0, 3, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].st, tbl[i].op, tbl[i].rd, tbl[i].rs1, 5'd0, 1'b0, tbl[i].rw);
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 32'(Busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_busyrd", i), 32'(BusyRd), 32'(tbl[i].e_brd));
      chk_stall($sformatf("tbl%0d", i), tbl[i].e_stall);
      chk($sformatf("tbl%0d_wben", i), 32'(WbEn), 32'(tbl[i].e_wb));
      if (tbl[i].e_wb) chk($sformatf("tbl%0d_wbrd", i), 32'(WbRd), 32'(tbl[i].e_wbrd));
      end_cycle();
    end

    // DIV rd7 with dependent Rs1D=7 held in D
    for (int c = 0; c <= 18; c++) begin
      drive(0, c == 0, 1, 7, 7, 0, 0, 0);
      @(negedge clk);
      chk_stall($sformatf("div_c%0d", c), c <= 17);
      chk($sformatf("div_c%0d_wben", c), 32'(WbEn), 32'(c == 17));
      chk($sformatf("div_c%0d_busy", c), 32'(Busy), 32'((c >= 1) && (c <= 17)));
      if (c == 17) chk("div_wbrd", 32'(WbRd), 32'd7);
      end_cycle();
    end

    // Structural conflict, then back-to-back MUL issued in the write cycle
    for (int c = 0; c <= 9; c++) begin
      drive(0, (c == 0) || (c == 4), 0, (c == 0) ? 5'd9 : 5'd10, 1, 2, c <= 4, 0);
      @(negedge clk);
      chk_stall($sformatf("str_c%0d", c), c <= 4);
      chk($sformatf("str_c%0d_wben", c), 32'(WbEn), 32'((c == 4) || (c == 8)));
      chk($sformatf("str_c%0d_busy", c), 32'(Busy), 32'((c >= 1) && (c <= 8)));
      if (c == 4) chk("str_wbrd0", 32'(WbRd), 32'd9);
      if (c == 8) chk("str_wbrd1", 32'(WbRd), 32'd10);
      if (c == 5) chk("str_busyrd", 32'(BusyRd), 32'd10);
      end_cycle();
    end

    // MUL to x0: never writes, never creates a dependency
    for (int c = 0; c <= 5; c++) begin
      drive(0, c == 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk_stall($sformatf("x0_c%0d", c), 1'b0);
      chk($sformatf("x0_c%0d_wben", c), 32'(WbEn), 32'd0);
      chk($sformatf("x0_c%0d_busy", c), 32'(Busy), 32'((c >= 1) && (c <= 4)));
      end_cycle();
    end

    // Reset pulsed mid-DIV, then a fresh MUL completes
    for (int c = 0; c <= 33; c++) begin
      drive(c == 6, (c == 0) || (c == 28), c == 0, (c == 0) ? 5'd7 : 5'd4,
            (c < 28) ? 5'd7 : 5'd0, 0, 0, 0);
      @(negedge clk);
      if (c >= 6) begin
        chk($sformatf("rst_c%0d_wben", c), 32'(WbEn), 32'(c == 32));
        chk($sformatf("rst_c%0d_busy", c), 32'(Busy), 32'((c >= 29) && (c <= 32)));
      end
      if (c == 6 || c == 7) begin
        chk($sformatf("rst_c%0d_busyrd", c), 32'(BusyRd), 32'd0);
        chk_stall($sformatf("rst_c%0d", c), 1'b0);
      end
      if (c >= 1 && c <= 5) chk_stall($sformatf("rst_c%0d", c), 1'b1);
      if (c == 32) chk("rst_wbrd", 32'(WbRd), 32'd4);
      end_cycle();
    end

    // Randomized pipeline: E receives D unless stalled (then a bubble)
    d_v = 0; d_md = 0; d_op = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    e_v = 0; e_md = 0; e_op = 0; e_rd = 0;
    m_have = 0; m_rd = 0; m_done = 0; cyc = 0;
    for (int n = 0; n < N_RAND; n++) begin
      r = (n == 0) || ($urandom_range(0, 199) == 0);
      drive(r, !r && e_v && e_md, e_op, e_rd, d_rs1, d_rs2, !r && d_v && d_md,
            $urandom_range(0, 2) == 0);
      if (r) begin
        m_have = 0;
        m_rd   = 0;
      end
      wp    = m_have && (cyc >= m_done);
      leave = wp && (!RegWriteW || (m_rd == 5'd0));
      x_wb  = wp && !RegWriteW && (m_rd != 5'd0);
      p     = StartE ? RdE : m_rd;
      x_h   = (StartE || m_have) &&
              (((p != 5'd0) && ((Rs1D == p) || (Rs2D == p))) || MulDivD);
      @(negedge clk);
      chk("rnd_busy", 32'(Busy), 32'(m_have));
      chk("rnd_busyrd", 32'(BusyRd), 32'(m_rd));
      chk_stall("rnd", x_h);
      chk("rnd_wben", 32'(WbEn), 32'(x_wb));
      if (x_wb) chk("rnd_wbrd", 32'(WbRd), 32'(m_rd));
      if (StartE) chk("rnd_start_legal", 32'(!m_have || leave), 32'd1);
      if (!r) begin
        if (StartE && (!m_have || leave)) begin
          m_have = 1;
          m_rd   = RdE;
          m_done = cyc + int'(OpE ? DIV_LAT : MUL_LAT) + 1;
        end else if (leave) begin
          m_have = 0;
        end
      end
      if (r) begin
        d_v = 0; e_v = 0;
      end else if (x_h) begin
        e_v = 0;
      end else begin
        e_v = d_v; e_md = d_md; e_op = d_op; e_rd = d_rd;
        d_v   = 1;
        d_md  = ($urandom_range(0, 2) == 0);
        d_op  = 1'($urandom_range(0, 1));
        d_rd  = 5'($urandom_range(0, 7));
        d_rs1 = 5'($urandom_range(0, 7));
        d_rs2 = 5'($urandom_range(0, 7));
      end
      end_cycle();
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
